free_block_fifo: RTL and testbench

Circular pool of erased (free) physical blocks for the NVM flash-translation layer. Sits directly downstream of the garbage-collection block: GC pushes each block it has erased (`recover_blk` / `fifo_recover_en` path), and the write allocator pops blocks to open as new active blocks. On initialization it self-loads every physical block ID. It raises a low-watermark flag that the overall controller uses to start garbage collection.

---
 rtl/free_block_fifo.sv | 139 +++++++++++++
 tb/tb_free_block_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/free_block_fifo.sv
// free_block_fifo: circular pool of erased physical block IDs for the FTL.
// GC pushes erased blocks, the write allocator pops them. An init load fills
// the pool with every block ID 0..NUM_BLK-1 in order.
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   init_en           start/restart a full initialization load
//   recover_en/_blk   push strobe and erased block ID from GC
//   alloc_req         pop request from the allocator
//   free_blk          head entry, valid when free_valid
//   free_valid        RUN and count > 0
//   free_count        current occupancy
//   init_busy         initialization load in progress
//   low_water         RUN and free_count <= LOW_WM
//   ovf_err           sticky: a push was refused
module free_block_fifo #(
    parameter int unsigned NUM_BLK = 64,
    parameter int unsigned BLK_W   = 6,
    parameter int unsigned LOW_WM  = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             init_en,
    input  logic                             recover_en,
    input  logic [BLK_W-1:0]                 recover_blk,
    input  logic                             alloc_req,
    output logic [BLK_W-1:0]                 free_blk,
    output logic                             free_valid,
    output logic [$clog2(NUM_BLK+1)-1:0]     free_count,
    output logic                             init_busy,
    output logic                             low_water,
    output logic                             ovf_err
);

    localparam int unsigned CNT_W = $clog2(NUM_BLK + 1);
    localparam int unsigned PTR_W = $clog2(NUM_BLK);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           state_q;
    logic [BLK_W-1:0] mem_q [NUM_BLK];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] init_cnt_q;
    logic             ovf_q;

    logic [PTR_W-1:0] wr_ptr_inc;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic             pop;
    logic             push;

    // Pointer wrap (NUM_BLK need not be a power of two) and RUN-state handshakes.
    always_comb begin
        wr_ptr_inc = (wr_ptr_q == PTR_W'(NUM_BLK - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        rd_ptr_inc = (rd_ptr_q == PTR_W'(NUM_BLK - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        pop        = 1'b0;
        push       = 1'b0;
        if (state_q == ST_RUN && !init_en) begin
            pop  = alloc_req && (count_q != '0);
            // A simultaneous pop frees the slot a full pool would otherwise lack.
            push = recover_en && ((32'(count_q) < NUM_BLK) || pop);
        end
    end

    // State machine, storage, pointers and sticky error.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            init_cnt_q <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < int'(NUM_BLK); i++) begin
                mem_q[i] <= '0;
            end
        end else if (init_en) begin
            // Restart from any state; ovf_err is deliberately kept.
            state_q    <= ST_INIT;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            init_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (recover_en) begin
                        ovf_q <= 1'b1;
                    end
                end
                ST_INIT: begin
                    mem_q[wr_ptr_q] <= BLK_W'(init_cnt_q);
                    wr_ptr_q        <= wr_ptr_inc;
                    count_q         <= count_q + CNT_W'(1);
                    init_cnt_q      <= init_cnt_q + CNT_W'(1);
                    if (32'(init_cnt_q) == NUM_BLK - 1) begin
                        state_q <= ST_RUN;
                    end
                    if (recover_en) begin
                        ovf_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (pop) begin
                        rd_ptr_q <= rd_ptr_inc;
                    end
                    if (push) begin
                        mem_q[wr_ptr_q] <= recover_blk;
                        wr_ptr_q        <= wr_ptr_inc;
                    end
                    if (push && !pop) begin
                        count_q <= count_q + CNT_W'(1);
                    end else if (pop && !push) begin
                        count_q <= count_q - CNT_W'(1);
                    end
                    if (recover_en && !push) begin
                        ovf_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

    // Outputs are simple functions of registered state.
    assign free_blk   = mem_q[rd_ptr_q];
    assign free_valid = (state_q == ST_RUN) && (count_q != '0);
    assign free_count = count_q;
    assign init_busy  = (state_q == ST_INIT);
    assign low_water  = (state_q == ST_RUN) && (32'(count_q) <= LOW_WM);
    assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_free_block_fifo.sv
// Bench for free_block_fifo: an 8-block and a 6-block pool checked against a
// queue-based reference model under directed and random stimulus.
module tb_free_block_fifo;

    localparam int M_EMPTY = 0;
    localparam int M_INIT  = 1;
    localparam int M_RUN   = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // Instance 0: NUM_BLK=8, LOW_WM=4. Instance 1: NUM_BLK=6, LOW_WM=2.
    logic       ie0 = 0, re0 = 0, ar0 = 0;
    logic [2:0] rb0 = 0;
    logic [2:0] fb0;
    logic       fv0, ib0, lw0, oe0;
    logic [3:0] fc0;

    logic       ie1 = 0, re1 = 0, ar1 = 0;
    logic [2:0] rb1 = 0;
    logic [2:0] fb1;
    logic       fv1, ib1, lw1, oe1;
    logic [2:0] fc1;

    free_block_fifo #(.NUM_BLK(8), .BLK_W(3), .LOW_WM(4)) dut0 (
        .CLK(CLK), .RST(RST), .init_en(ie0), .recover_en(re0), .recover_blk(rb0),
        .alloc_req(ar0), .free_blk(fb0), .free_valid(fv0), .free_count(fc0),
        .init_busy(ib0), .low_water(lw0), .ovf_err(oe0)
    );

    free_block_fifo #(.NUM_BLK(6), .BLK_W(3), .LOW_WM(2)) dut1 (
        .CLK(CLK), .RST(RST), .init_en(ie1), .recover_en(re1), .recover_blk(rb1),
        .alloc_req(ar1), .free_blk(fb1), .free_valid(fv1), .free_count(fc1),
        .init_busy(ib1), .low_water(lw1), .ovf_err(oe1)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: mode, init progress, sticky error and a queue per pool.
    int mode [2];
    int kinit[2];
    int ovf  [2];
    int nblk [2] = '{8, 6};
    int lwm  [2] = '{4, 2};
    int q0[$];
    int q1[$];

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int j);
        return (j == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int qhead(input int j);
        return (j == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpush(input int j, input int v);
        if (j == 0) q0.push_back(v); else q1.push_back(v);
    endtask

    task automatic qpop(input int j);
        int d;
        if (j == 0) d = q0.pop_front(); else d = q1.pop_front();
    endtask

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            mode[j] = M_EMPTY; kinit[j] = 0; ovf[j] = 0;
        end
        q0.delete(); q1.delete();
    endtask

    task automatic model_edge(input int j, input int init, input int rec, input int blk, input int alloc);
        int p, s;
        if (init != 0) begin
            mode[j] = M_INIT; kinit[j] = 0;
            if (j == 0) q0.delete(); else q1.delete();
        end else if (mode[j] == M_EMPTY) begin
            if (rec != 0) ovf[j] = 1;
        end else if (mode[j] == M_INIT) begin
            qpush(j, kinit[j]);
            kinit[j]++;
            if (kinit[j] == nblk[j]) mode[j] = M_RUN;
            if (rec != 0) ovf[j] = 1;
        end else begin
            p = (alloc != 0 && qsize(j) > 0) ? 1 : 0;
            s = (rec != 0 && (qsize(j) < nblk[j] || p == 1)) ? 1 : 0;
            if (p == 1) qpop(j);
            if (s == 1) qpush(j, blk);
            if (rec != 0 && s == 0) ovf[j] = 1;
        end
    endtask

    task automatic check_all(input string tag);
        int v;
        for (int j = 0; j < 2; j++) begin
            v = (mode[j] == M_RUN && qsize(j) > 0) ? 1 : 0;
            if (j == 0) begin
                chk($sformatf("%s/p0 count", tag), int'(fc0), qsize(0));
                chk($sformatf("%s/p0 valid", tag), int'(fv0), v);
                if (v == 1) chk($sformatf("%s/p0 blk", tag), int'(fb0), qhead(0));
                chk($sformatf("%s/p0 busy", tag), int'(ib0), (mode[0] == M_INIT) ? 1 : 0);
                chk($sformatf("%s/p0 low", tag), int'(lw0), (mode[0] == M_RUN && qsize(0) <= lwm[0]) ? 1 : 0);
                chk($sformatf("%s/p0 ovf", tag), int'(oe0), ovf[0]);
            end else begin
                chk($sformatf("%s/p1 count", tag), int'(fc1), qsize(1));
                chk($sformatf("%s/p1 valid", tag), int'(fv1), v);
                if (v == 1) chk($sformatf("%s/p1 blk", tag), int'(fb1), qhead(1));
                chk($sformatf("%s/p1 busy", tag), int'(ib1), (mode[1] == M_INIT) ? 1 : 0);
                chk($sformatf("%s/p1 low", tag), int'(lw1), (mode[1] == M_RUN && qsize(1) <= lwm[1]) ? 1 : 0);
                chk($sformatf("%s/p1 ovf", tag), int'(oe1), ovf[1]);
            end
        end
    endtask

    task automatic drive(input int j, input int init, input int rec, input int blk, input int alloc);
        if (j == 0) begin
            ie0 = 1'(init); re0 = 1'(rec); rb0 = 3'(blk); ar0 = 1'(alloc);
        end else begin
            ie1 = 1'(init); re1 = 1'(rec); rb1 = 3'(blk); ar1 = 1'(alloc);
        end
    endtask

    // One clock edge: model follows the driven inputs, outputs checked 1 time unit later.
    task automatic tick(input string tag);
        @(posedge CLK);
        model_edge(0, int'(ie0), int'(re0), int'(rb0), int'(ar0));
        model_edge(1, int'(ie1), int'(re1), int'(rb1), int'(ar1));
        #1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        chk("reset p0 blk", int'(fb0), 0);
        RST = 1'b0;

        // Init of pool 0: init_busy for exactly 8 edges.
        drive(0, 1, 0, 0, 0); tick("init_start");
        for (int i = 0; i < 8; i++) begin
            chk("init busy", int'(ib0), 1);
            tick("init_load");
        end
        chk("init done count", int'(fc0), 8);
        chk("init done valid", int'(fv0), 1);
        chk("init done blk", int'(fb0), 0);
        chk("init done low", int'(lw0), 0);

        // Order after init: 3 pops, push 5,1,2, then drain 8.
        for (int i = 0; i < 3; i++) begin
            chk("order first pops", int'(fb0), i);
            drive(0, 0, 0, 0, 1); tick("pop3");
        end
        drive(0, 0, 1, 5, 0); tick("push5");
        drive(0, 0, 1, 1, 0); tick("push1");
        drive(0, 0, 1, 2, 0); tick("push2");
        chk("order count", int'(fc0), 8);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 1); tick("drain");
        end

        // Empty with simultaneous push and alloc: push only, no bypass.
        drive(0, 0, 1, 6, 1); tick("empty_simul");
        chk("empty simul count", int'(fc0), 1);
        chk("empty simul blk", int'(fb0), 6);

        // Fill to 8, then push+pop at full, then refused push.
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 1, i, 0); tick("fill");
        end
        drive(0, 0, 1, 3, 1); tick("full_simul");
        chk("full simul count", int'(fc0), 8);
        chk("full simul ovf", int'(oe0), 0);
        drive(0, 0, 1, 4, 0); tick("full_push");
        chk("full push ovf", int'(oe0), 1);
        tick("ovf_sticky");

        // Pool 1 (6 blocks): init, then 20 pop/push pairs across the wrap.
        drive(1, 1, 0, 0, 0); tick("p1_init");
        for (int i = 0; i < 6; i++) tick("p1_load");
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0, 1); tick("wrap_pop");
            drive(1, 0, 1, int'($urandom_range(0, 5)), 0); tick("wrap_push");
            chk("wrap count bound", (int'(fc1) <= 6) ? 1 : 0, 1);
        end

        // Reset during init cycle 3 of pool 0.
        drive(0, 1, 0, 0, 0); tick("reinit");
        for (int i = 0; i < 3; i++) tick("reinit_load");
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        chk("async reset p0 blk", int'(fb0), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        drive(0, 1, 0, 0, 0); tick("post_reset_init");
        for (int i = 0; i < 8; i++) tick("post_reset_load");
        for (int i = 0; i < 8; i++) begin
            chk("post reset order", int'(fb0), i);
            drive(0, 0, 0, 0, 1); tick("post_reset_pop");
        end

        // Random traffic on both pools.
        drive(1, 1, 0, 0, 0); tick("rand_p1_init");
        for (int n = 0; n < 600; n++) begin
            for (int j = 0; j < 2; j++) begin
                drive(j, ($urandom_range(0, 199) == 0) ? 1 : 0,
                      int'($urandom_range(0, 1)),
                      int'($urandom_range(0, nblk[j] - 1)),
                      int'($urandom_range(0, 1)));
            end
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
